// File: rtl/car_cruise_fsm.sv
// Cruise-style car controller: light-driven GO/SLOW/STOP/PARK FSM with a modelled speed register.
// Optional obstacle input and emergency braking enabled by defining CAR_OBSTACLE_EN.

`ifndef GREEN
`define GREEN 2'b00
`endif
`ifndef YELLOW
`define YELLOW 2'b01
`endif
`ifndef RED
`define RED 2'b10
`endif

module car_cruise_fsm #(
   parameter int unsigned SPEED_W    = 8,
   parameter int unsigned MAX_SPEED  = 100,
   parameter int unsigned SLOW_SPEED = 30,
   parameter int unsigned ACCEL      = 2,
   parameter int unsigned DECEL      = 4,
   parameter int unsigned PARK_DELAY = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         trafficlight,
`ifdef CAR_OBSTACLE_EN
   input  logic               obstacle,
`endif
   output logic               gas,
   output logic               brakes,
   output logic               park,
   output logic [SPEED_W-1:0] speed,
   output logic [1:0]         state_o
);

   localparam int unsigned CNT_W = $clog2(PARK_DELAY) + 1;
   // Two extra bits keep sums and doubled deceleration from wrapping.
   localparam int unsigned EW = SPEED_W + 2;
   localparam logic [EW-1:0] MAX_X  = EW'(MAX_SPEED);
   localparam logic [EW-1:0] SLOW_X = EW'(SLOW_SPEED);
   localparam logic [EW-1:0] ACC_X  = EW'(ACCEL);
   localparam logic [EW-1:0] DEC_X  = EW'(DECEL);
   localparam logic [EW-1:0] DEC2_X = EW'(2 * DECEL);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PARK_DELAY - 1);

   typedef enum logic [1:0] {
      ST_GO   = 2'b00,
      ST_SLOW = 2'b01,
      ST_STOP = 2'b10,
      ST_PARK = 2'b11
   } state_t;

   state_t             state, state_n;
   logic [SPEED_W-1:0] speed_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               obs;
   logic               is_green, is_yellow;
   logic [EW-1:0]      spd_x, sum_x, stop_dec;

`ifdef CAR_OBSTACLE_EN
   assign obs = obstacle;
`else
   assign obs = 1'b0;
`endif

   // State, speed and hold-counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_PARK;
         speed <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         speed <= speed_n;
         cnt   <= cnt_n;
      end
   end

   // Next state, next speed (from pre-edge state) and hold counter
   always_comb begin
      state_n   = state;
      speed_n   = speed;
      cnt_n     = '0;
      is_green  = (trafficlight == `GREEN);
      is_yellow = (trafficlight == `YELLOW);
      spd_x     = EW'(speed);
      sum_x     = spd_x + ACC_X;
      stop_dec  = obs ? DEC2_X : DEC_X;

      case (state)
         ST_GO:   speed_n = (sum_x > MAX_X) ? SPEED_W'(MAX_SPEED) : SPEED_W'(sum_x);
         ST_SLOW: begin
            if (spd_x > SLOW_X)
               speed_n = (spd_x > SLOW_X + DEC_X) ? SPEED_W'(spd_x - DEC_X) : SPEED_W'(SLOW_SPEED);
         end
         ST_STOP: speed_n = (spd_x > stop_dec) ? SPEED_W'(spd_x - stop_dec) : '0;
         default: speed_n = '0;
      endcase

      if (state == ST_STOP && speed == '0)
         cnt_n = cnt + CNT_W'(1);

      if (obs && state != ST_PARK) begin
         state_n = ST_STOP;
      end else if (is_green) begin
         state_n = ST_GO;
      end else if (is_yellow) begin
         if (state == ST_GO || state == ST_SLOW)
            state_n = ST_SLOW;
      end else begin
         // RED and any undefined code
         case (state)
            ST_GO, ST_SLOW: state_n = ST_STOP;
            ST_STOP: begin
               if (speed == '0 && cnt == HOLD_LAST)
                  state_n = ST_PARK;
            end
            default: state_n = state;
         endcase
      end
   end

   // Actuator outputs from registered state and speed
   always_comb begin
      gas     = 1'b0;
      brakes  = 1'b0;
      park    = 1'b0;
      state_o = state;
      case (state)
         ST_GO:   gas    = 1'b1;
         ST_SLOW: brakes = (EW'(speed) > SLOW_X);
         ST_STOP: brakes = 1'b1;
         default: begin
            brakes = 1'b1;
            park   = 1'b1;
         end
      endcase
   end

endmodule
